// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared field widths, status-flag bit positions and the grouped pipeline-register types
// used between the ID and EXE stages.
package id_exe_pipe_reg_pkg;

  localparam int REG_IDX_W = 4;
  localparam int CMD_W     = 4;
  localparam int IMM24_W   = 24;
  localparam int SHOP_W    = 12;

  // NZCV layout of the status register as seen by EXE
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;
  localparam int SR_W = SR_N + 1;

  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
    logic b;
    logic s;
  } ctrl_t;

  typedef struct packed {
    logic [IMM24_W-1:0]   imm24;
    logic [SHOP_W-1:0]    shift_op;
    logic [CMD_W-1:0]     exe_cmd;
    logic [REG_IDX_W-1:0] dest;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic [SR_W-1:0]      sr;
    logic                 imm;
  } fields_t;

  // A bubble must never commit, so its side-effecting control bits are forced low.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic vld);
    return vld ? c : '0;
  endfunction

endpackage

// File: rtl/id_exe_pipe_reg_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with freeze (stall), flush (squash) and bubble insertion,
// plus saturating stall/flush debug counters.
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    valRn_in,
  input  logic [DATA_W-1:0]    valRm_in,
  input  logic [IMM24_W-1:0]   signedimm_in,
  input  logic [SHOP_W-1:0]    shiftOp_in,
  input  logic [CMD_W-1:0]     exeCmd_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [REG_IDX_W-1:0] src1_in,
  input  logic [REG_IDX_W-1:0] src2_in,
  input  logic                 imm_in,
  input  logic                 wbEn_in,
  input  logic                 memRead_in,
  input  logic                 memWrite_in,
  input  logic                 b_in,
  input  logic                 s_in,
  input  logic [SR_W-1:0]      sr_in,
  output logic                 valid_out,
  output logic [DATA_W-1:0]    pc_out,
  output logic [DATA_W-1:0]    valRn_out,
  output logic [DATA_W-1:0]    valRm_out,
  output logic [IMM24_W-1:0]   signedimm_out,
  output logic [SHOP_W-1:0]    shiftOp_out,
  output logic [CMD_W-1:0]     exeCmd_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [REG_IDX_W-1:0] src1_out,
  output logic [REG_IDX_W-1:0] src2_out,
  output logic                 imm_out,
  output logic                 wbEn_out,
  output logic                 memRead_out,
  output logic                 memWrite_out,
  output logic                 b_out,
  output logic                 s_out,
  output logic [SR_W-1:0]      sr_out,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rn_q, rn_d;
  logic [DATA_W-1:0] rm_q, rm_d;
  ctrl_t             ctrl_q, ctrl_d, ctrl_in;
  fields_t           fld_q, fld_d, fld_in;

  assign ctrl_in = '{wb_en: wbEn_in, mem_read: memRead_in, mem_write: memWrite_in,
                     b: b_in, s: s_in};
  assign fld_in  = '{imm24: signedimm_in, shift_op: shiftOp_in, exe_cmd: exeCmd_in,
                     dest: dest_in, src1: src1_in, src2: src2_in, sr: sr_in, imm: imm_in};

  // Priority: flush beats freeze beats load; hold is the default.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    ctrl_d  = ctrl_q;
    fld_d   = fld_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      rn_d    = '0;
      rm_d    = '0;
      ctrl_d  = '0;
      fld_d   = '0;
    end else if (!freeze) begin
      valid_d = valid_in;
      pc_d    = pc_in;
      rn_d    = valRn_in;
      rm_d    = valRm_in;
      ctrl_d  = gate_ctrl(ctrl_in, valid_in);
      fld_d   = fld_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      ctrl_q  <= '0;
      fld_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      ctrl_q  <= ctrl_d;
      fld_q   <= fld_d;
    end
  end

  assign valid_out     = valid_q;
  assign pc_out        = pc_q;
  assign valRn_out     = rn_q;
  assign valRm_out     = rm_q;
  assign signedimm_out = fld_q.imm24;
  assign shiftOp_out   = fld_q.shift_op;
  assign exeCmd_out    = fld_q.exe_cmd;
  assign dest_out      = fld_q.dest;
  assign src1_out      = fld_q.src1;
  assign src2_out      = fld_q.src2;
  assign sr_out        = fld_q.sr;
  assign imm_out       = fld_q.imm;
  assign wbEn_out      = ctrl_q.wb_en;
  assign memRead_out   = ctrl_q.mem_read;
  assign memWrite_out  = ctrl_q.mem_write;
  assign b_out         = ctrl_q.b;
  assign s_out         = ctrl_q.s;

  // A flush cycle is not a stall even when freeze is also high.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze & ~flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule
